dmem_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and access sequencer for the 16-bit word data memory.

---
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester, status and memory-side signals of the two-port data-memory arbiter.
// master = requesters plus the memory model, slave = the arbiter itself.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              err;
  logic              busy;
  logic              grant_id;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_datain;
  logic              mem_memread;
  logic              mem_memwrite;
  logic [DATA_W-1:0] mem_dataout;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataout,
    input  ack0, ack1, rdata0, rdata1, err, busy, grant_id,
    input  mem_address, mem_datain, mem_memread, mem_memwrite
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataout,
    output ack0, ack1, rdata0, rdata1, err, busy, grant_id,
    output mem_address, mem_datain, mem_memread, mem_memwrite
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and single-access sequencer for the word data memory.
// IDLE -> ACCESS (one strobe cycle) -> DONE (one ack cycle) -> IDLE; all outputs registered.
module dmem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = MEM_DEPTH[ADDR_W:0];

  state_t            state_r;
  logic              last_grant_r;
  logic              we_r;
  logic              in_range_r;
  logic              ack0_r;
  logic              ack1_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;
  logic              err_r;
  logic              busy_r;
  logic              grant_id_r;
  logic [ADDR_W-1:0] mem_address_r;
  logic [DATA_W-1:0] mem_datain_r;
  logic              mem_memread_r;
  logic              mem_memwrite_r;

  logic              any_req_s;
  logic              grant_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              in_range_s;

  // Winner selection: sole requester, or on a tie the port that did not win last time.
  always_comb begin
    any_req_s   = bus.req0 | bus.req1;
    grant_s     = 1'b0;
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (bus.req0 && bus.req1) begin
      grant_s = ~last_grant_r;
    end else if (bus.req1) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (grant_s) begin
      sel_we_s    = bus.we1;
      sel_addr_s  = bus.addr1;
      sel_wdata_s = bus.wdata1;
    end else begin
      sel_we_s    = bus.we0;
      sel_addr_s  = bus.addr0;
      sel_wdata_s = bus.wdata0;
    end
    in_range_s = ({1'b0, sel_addr_s} < DEPTH_L);
  end

  // Sequencer FSM with all outputs registered; strobes are set on the grant edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      last_grant_r   <= 1'b1;
      we_r           <= 1'b0;
      in_range_r     <= 1'b0;
      ack0_r         <= 1'b0;
      ack1_r         <= 1'b0;
      rdata0_r       <= '0;
      rdata1_r       <= '0;
      err_r          <= 1'b0;
      busy_r         <= 1'b0;
      grant_id_r     <= 1'b0;
      mem_address_r  <= '0;
      mem_datain_r   <= '0;
      mem_memread_r  <= 1'b0;
      mem_memwrite_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_r        <= ST_ACCESS;
            grant_id_r     <= grant_s;
            last_grant_r   <= grant_s;
            we_r           <= sel_we_s;
            in_range_r     <= in_range_s;
            mem_address_r  <= sel_addr_s;
            mem_datain_r   <= sel_wdata_s;
            mem_memread_r  <= in_range_s & ~sel_we_s;
            mem_memwrite_r <= in_range_s & sel_we_s;
            busy_r         <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state_r        <= ST_DONE;
          mem_memread_r  <= 1'b0;
          mem_memwrite_r <= 1'b0;
          err_r          <= ~in_range_r;
          if (grant_id_r) begin
            ack1_r <= 1'b1;
          end else begin
            ack0_r <= 1'b1;
          end
          // Out-of-range accesses of either kind report zero data.
          if (!in_range_r || !we_r) begin
            if (grant_id_r) begin
              rdata1_r <= in_range_r ? bus.mem_dataout : '0;
            end else begin
              rdata0_r <= in_range_r ? bus.mem_dataout : '0;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          ack0_r  <= 1'b0;
          ack1_r  <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r        <= ST_IDLE;
          ack0_r         <= 1'b0;
          ack1_r         <= 1'b0;
          err_r          <= 1'b0;
          busy_r         <= 1'b0;
          mem_memread_r  <= 1'b0;
          mem_memwrite_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack0         = ack0_r;
  assign bus.ack1         = ack1_r;
  assign bus.rdata0       = rdata0_r;
  assign bus.rdata1       = rdata1_r;
  assign bus.err          = err_r;
  assign bus.busy         = busy_r;
  assign bus.grant_id     = grant_id_r;
  assign bus.mem_address  = mem_address_r;
  assign bus.mem_datain   = mem_datain_r;
  assign bus.mem_memread  = mem_memread_r;
  assign bus.mem_memwrite = mem_memwrite_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized two-port
// stream checked against a transaction-level reference model (memory array + expected rdata).
module tb_dmem_arbiter;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Memory stub: combinational read, write commits on the clock edge.
  logic [15:0] tb_mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;
  always @(posedge clk) begin
    if (pre_we) tb_mem[pre_addr] <= pre_data;
    else if (bus.mem_memwrite) tb_mem[bus.mem_address[7:0]] <= bus.mem_datain;
  end
  assign bus.mem_dataout = tb_mem[bus.mem_address[7:0]];

  logic [15:0] ref_mem [0:255];
  logic [15:0] exp_rd  [0:1];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic drive_port(input int p, input logic r, input logic w,
                            input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  function automatic logic get_ack(input int p);
    return (p == 0) ? bus.ack0 : bus.ack1;
  endfunction

  function automatic logic [15:0] get_rd(input int p);
    return (p == 0) ? bus.rdata0 : bus.rdata1;
  endfunction

  // Issue one request, wait (bounded) for its ack, drop req in the ack cycle.
  task automatic run_txn(input int p, input logic w, input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output logic er, output int lat);
    rd = 16'h0000; er = 1'b0; lat = -1;
    drive_port(p, 1'b1, w, a, d);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (get_ack(p)) begin
        lat = c; rd = get_rd(p); er = bus.err;
        break;
      end
    end
    drive_port(p, 1'b0, w, a, d);
    @(negedge clk);
  endtask

  task automatic preload_mem();
    reset = 1'b1;
    drive_port(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_port(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = i[7:0]; pre_data = 16'($urandom);
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [70:0] obs;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_rd[0] = 16'h0000; exp_rd[1] = 16'h0000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      obs = {bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, bus.err, bus.busy, bus.grant_id,
             bus.mem_address, bus.mem_datain, bus.mem_memread, bus.mem_memwrite};
      n_checks++;
      if (obs !== 71'd0) begin
        n_fail++; $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, obs);
      end
    end
  endtask

  task automatic test_tie();
    int seq_p[$];
    int seq_c[$];
    drive_port(0, 1'b1, 1'b0, 16'h0001, 16'h0000);
    drive_port(1, 1'b1, 1'b0, 16'h0002, 16'h0000);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (bus.ack0) begin
        seq_p.push_back(0); seq_c.push_back(c);
        n_checks++;
        if (bus.rdata0 !== ref_mem[1]) begin
          n_fail++; $display("FAIL tie_rdata0: got %h expected %h", bus.rdata0, ref_mem[1]);
        end
      end
      if (bus.ack1) begin
        seq_p.push_back(1); seq_c.push_back(c);
        n_checks++;
        if (bus.rdata1 !== ref_mem[2]) begin
          n_fail++; $display("FAIL tie_rdata1: got %h expected %h", bus.rdata1, ref_mem[2]);
        end
      end
    end
    drive_port(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_port(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    exp_rd[0] = ref_mem[1]; exp_rd[1] = ref_mem[2];
    n_checks++;
    if (seq_p.size() != 4) begin
      n_fail++; $display("FAIL tie_ack_count: got %0d expected 4", seq_p.size());
    end
    for (int k = 0; k < seq_p.size() && k < 4; k++) begin
      n_checks++;
      if (seq_p[k] != (k % 2) || seq_c[k] != 2 + 3 * k) begin
        n_fail++;
        $display("FAIL tie_order ack %0d: got port %0d cycle %0d expected port %0d cycle %0d",
                 k, seq_p[k], seq_c[k], k % 2, 2 + 3 * k);
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL tie_idle_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_write_read();
    int wcnt = 0, rcnt = 0, ack_c = -1;
    logic er_s = 1'b0;
    logic [15:0] rd_s = 16'h0000;
    logic [15:0] rd;
    logic er;
    int lat;
    drive_port(0, 1'b1, 1'b1, 16'h0005, 16'hBEEF);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.mem_memwrite) wcnt++;
      if (bus.mem_memread) rcnt++;
      if (c == 1) begin
        n_checks++;
        if ({bus.mem_address, bus.mem_datain, bus.busy, bus.grant_id} !== {16'h0005, 16'hBEEF, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL wr_access_bus: got addr %h data %h busy %b gid %b expected 0005 beef 1 0",
                   bus.mem_address, bus.mem_datain, bus.busy, bus.grant_id);
        end
      end
      if (bus.ack0 && ack_c < 0) begin
        ack_c = c; er_s = bus.err; rd_s = bus.rdata0;
        drive_port(0, 1'b0, 1'b1, 16'h0005, 16'hBEEF);
      end
    end
    ref_mem[5] = 16'hBEEF;
    n_checks++;
    if (wcnt != 1 || rcnt != 0) begin
      n_fail++; $display("FAIL wr_strobes: got write %0d read %0d cycles expected 1 0", wcnt, rcnt);
    end
    n_checks++;
    if (ack_c != 2 || er_s !== 1'b0 || rd_s !== exp_rd[0]) begin
      n_fail++;
      $display("FAIL wr_ack: got cycle %0d err %b rdata0 %h expected 2 0 %h", ack_c, er_s, rd_s, exp_rd[0]);
    end
    run_txn(0, 1'b0, 16'h0005, 16'h0000, rd, er, lat);
    exp_rd[0] = 16'hBEEF;
    n_checks++;
    if (lat != 2 || er !== 1'b0 || rd !== 16'hBEEF) begin
      n_fail++; $display("FAIL rd_after_wr: got lat %0d err %b rdata0 %h expected 2 0 beef", lat, er, rd);
    end
  endtask

  task automatic test_out_of_range();
    int scnt = 0, ack_c = -1;
    logic er_s = 1'b0;
    logic [15:0] rd_s = 16'hFFFF;
    logic [15:0] rd;
    logic er;
    int lat;
    drive_port(1, 1'b1, 1'b1, 16'h0100, 16'h1234);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.mem_memwrite || bus.mem_memread) scnt++;
      if (bus.ack1 && ack_c < 0) begin
        ack_c = c; er_s = bus.err; rd_s = bus.rdata1;
        drive_port(1, 1'b0, 1'b1, 16'h0100, 16'h1234);
      end
    end
    exp_rd[1] = 16'h0000;
    n_checks++;
    if (scnt != 0) begin
      n_fail++; $display("FAIL oor_strobes: got %0d strobe cycles expected 0", scnt);
    end
    n_checks++;
    if (ack_c != 2 || er_s !== 1'b1 || rd_s !== 16'h0000) begin
      n_fail++; $display("FAIL oor_ack: got cycle %0d err %b rdata1 %h expected 2 1 0000", ack_c, er_s, rd_s);
    end
    run_txn(1, 1'b0, 16'h0000, 16'h0000, rd, er, lat);
    exp_rd[1] = ref_mem[0];
    n_checks++;
    if (lat != 2 || er !== 1'b0 || rd !== ref_mem[0]) begin
      n_fail++; $display("FAIL oor_addr0_intact: got lat %0d err %b rdata1 %h expected 2 0 %h", lat, er, rd, ref_mem[0]);
    end
    run_txn(0, 1'b0, 16'h00FF, 16'h0000, rd, er, lat);
    exp_rd[0] = ref_mem[255];
    n_checks++;
    if (lat != 2 || er !== 1'b0 || rd !== ref_mem[255]) begin
      n_fail++; $display("FAIL last_word_read: got lat %0d err %b rdata0 %h expected 2 0 %h", lat, er, rd, ref_mem[255]);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] old;
    int seen = 0;
    old = ref_mem[16];
    drive_port(0, 1'b1, 1'b1, 16'h0010, ~old);
    @(negedge clk);
    n_checks++;
    if (bus.mem_memwrite !== 1'b1) begin
      n_fail++; $display("FAIL rmid_in_access: got memwrite %b expected 1", bus.mem_memwrite);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.mem_memwrite, bus.busy, bus.ack0} !== 3'b000) begin
      n_fail++; $display("FAIL rmid_async_drop: got memwrite/busy/ack0 %b expected 000",
                         {bus.mem_memwrite, bus.busy, bus.ack0});
    end
    drive_port(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_rd[0] = 16'h0000; exp_rd[1] = 16'h0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rmid_no_ack: got %0d ack cycles expected 0", seen);
    end
    drive_port(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    drive_port(1, 1'b1, 1'b0, 16'h0003, 16'h0000);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.ack0, bus.ack1} !== 2'b10 || bus.rdata0 !== old) begin
      n_fail++; $display("FAIL rmid_first_tie: got ack0/ack1 %b rdata0 %h expected 10 %h",
                         {bus.ack0, bus.ack1}, bus.rdata0, old);
    end
    drive_port(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_port(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    exp_rd[0] = old;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop_after_grant();
    logic [15:0] rd;
    logic er;
    int lat;
    run_txn(1, 1'b1, 16'h0007, 16'h00AA, rd, er, lat);
    ref_mem[7] = 16'h00AA;
    n_checks++;
    if (lat != 2 || er !== 1'b0 || rd !== exp_rd[1]) begin
      n_fail++; $display("FAIL drop_setup_write: got lat %0d err %b rdata1 %h expected 2 0 %h", lat, er, rd, exp_rd[1]);
    end
    drive_port(1, 1'b1, 1'b0, 16'h0007, 16'h0000);
    @(negedge clk);
    drive_port(1, 1'b0, 1'b1, 16'h0055, 16'h5555);
    @(negedge clk);
    exp_rd[1] = 16'h00AA;
    n_checks++;
    if (bus.ack1 !== 1'b1 || bus.rdata1 !== 16'h00AA || bus.rdata0 !== exp_rd[0]) begin
      n_fail++; $display("FAIL drop_ack: got ack1 %b rdata1 %h rdata0 %h expected 1 00aa %h",
                         bus.ack1, bus.rdata1, bus.rdata0, exp_rd[0]);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.ack1, bus.busy, bus.err} !== 3'b000) begin
      n_fail++; $display("FAIL drop_pulse_end: got ack1/busy/err %b expected 000", {bus.ack1, bus.busy, bus.err});
    end
  endtask

  task automatic test_random();
    int act[2], cool[2], wait_c[2], other[2];
    logic rw[2];
    logic [15:0] ra[2], rwd[2];
    logic exp_err;
    for (int p = 0; p < 2; p++) begin
      act[p] = 0; cool[p] = 0; wait_c[p] = 0; other[p] = 0;
      rw[p] = 1'b0; ra[p] = 16'h0000; rwd[p] = 16'h0000;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      n_checks++;
      if ((bus.mem_memread && bus.mem_memwrite) || (bus.ack0 && bus.ack1)) begin
        n_fail++; $display("FAIL rnd_exclusive cycle %0d: rd/wr %b%b ack %b%b expected never both",
                           cyc, bus.mem_memread, bus.mem_memwrite, bus.ack0, bus.ack1);
      end
      for (int p = 0; p < 2; p++) begin
        if (get_ack(p)) begin
          n_checks++;
          if (act[p] == 0) begin
            n_fail++; $display("FAIL rnd_spurious_ack port %0d cycle %0d: got ack expected none", p, cyc);
          end else begin
            exp_err = (ra[p] >= 16'd256);
            if (exp_err) exp_rd[p] = 16'h0000;
            else if (!rw[p]) exp_rd[p] = ref_mem[ra[p][7:0]];
            else ref_mem[ra[p][7:0]] = rwd[p];
            if (bus.err !== exp_err || get_rd(p) !== exp_rd[p] || get_rd(1 - p) !== exp_rd[1 - p]) begin
              n_fail++;
              $display("FAIL rnd_result port %0d addr %h we %b: got err %b rd %h other %h expected %b %h %h",
                       p, ra[p], rw[p], bus.err, get_rd(p), get_rd(1 - p), exp_err, exp_rd[p], exp_rd[1 - p]);
            end
            n_checks++;
            if (other[p] > 1) begin
              n_fail++; $display("FAIL rnd_fairness port %0d: got %0d foreign acks while waiting expected <=1", p, other[p]);
            end
            if (act[1 - p] != 0) other[1 - p]++;
          end
          act[p] = 0;
          cool[p] = $urandom_range(0, 2);
          drive_port(p, 1'b0, rw[p], ra[p], rwd[p]);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (act[p] != 0) begin
          wait_c[p]++;
          if (wait_c[p] > 12) begin
            n_checks++; n_fail++;
            $display("FAIL rnd_timeout port %0d: got no ack after %0d cycles expected ack", p, wait_c[p]);
            act[p] = 0;
            drive_port(p, 1'b0, rw[p], ra[p], rwd[p]);
          end
        end else if (cool[p] > 0) begin
          cool[p]--;
        end else if (cyc < 780 && ($urandom % 4) != 0) begin
          rw[p]  = 1'($urandom % 2);
          ra[p]  = (($urandom % 8) == 0) ? 16'(16'h0100 + $urandom_range(0, 16'hFEFF))
                                         : 16'($urandom_range(0, 255));
          rwd[p] = 16'($urandom);
          act[p] = 1; wait_c[p] = 0; other[p] = 0;
          drive_port(p, 1'b1, rw[p], ra[p], rwd[p]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    preload_mem();
    test_reset();
    test_tie();
    test_write_read();
    test_out_of_range();
    test_reset_mid();
    test_drop_after_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
